// File: rtl/bsg_fma_pkg.sv
// Shared types for the iterative fma helper blocks.
package bsg_fma_pkg;

  localparam int fma_width_gp = 32;
  localparam int fma_ctr_w_gp = $clog2(fma_width_gp);

  typedef enum logic [1:0] {IDLE, CALC, DONE} fma_state_e;

  // Sign corrections to apply once the unsigned core finishes.
  typedef struct packed {
    logic q_neg;
    logic r_neg;
  } div_sign_s;

endpackage

// File: rtl/bsg_fma_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to subtract the divisor.
module bsg_fma_div_step #(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] rem,
  input  logic               dvd_msb,
  input  logic [width_p-1:0] divisor,
  output logic [width_p-1:0] rem_nxt,
  output logic               q_bit
);

  logic [width_p:0] shifted;
  logic [width_p:0] trial;

  assign shifted = {rem, dvd_msb};
  assign trial   = shifted - {1'b0, divisor};

  // rem < divisor keeps shifted below 2*divisor, so trial's top bit is a clean borrow flag.
  assign q_bit   = ~trial[width_p];
  assign rem_nxt = q_bit ? trial[width_p-1:0] : shifted[width_p-1:0];

endmodule

// File: rtl/bsg_fma_int_div.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, valid/yumi result handshake.
module bsg_fma_int_div
  import bsg_fma_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] opA_i,
  input  logic [width_p-1:0] opB_i,
  input  logic               signed_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o,
  output logic               div_by_zero_o
);

  localparam int ctr_w_lp = $clog2(width_p);
  localparam logic [ctr_w_lp-1:0] last_lp = ctr_w_lp'(width_p - 1);

  fma_state_e          state;
  logic [ctr_w_lp-1:0] cnt;
  logic [width_p-1:0]  dvd, divisor, rem, quo;
  div_sign_s           sgn;

  logic               sign_a, sign_b;
  logic [width_p-1:0] abs_a, abs_b;
  logic [width_p-1:0] rem_nxt, q_fin, q_out, r_out;
  logic               q_bit;

  assign sign_a = signed_i & opA_i[width_p-1];
  assign sign_b = signed_i & opB_i[width_p-1];
  assign abs_a  = sign_a ? -opA_i : opA_i;
  assign abs_b  = sign_b ? -opB_i : opB_i;

  bsg_fma_div_step #(.width_p(width_p)) step (
    .rem     (rem),
    .dvd_msb (dvd[width_p-1]),
    .divisor (divisor),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  assign q_fin = {quo[width_p-2:0], q_bit};
  // -2^(w-1)/-1 negates 0x80..0 back onto itself, which is the wanted overflow result.
  assign q_out = sgn.q_neg ? -q_fin : q_fin;
  assign r_out = sgn.r_neg ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      ready_o       <= 1'b1;
      v_o           <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
      cnt           <= '0;
      dvd           <= '0;
      divisor       <= '0;
      rem           <= '0;
      quo           <= '0;
      sgn           <= '0;
    end else begin
      case (state)
        IDLE: if (v_i) begin
          sgn     <= '{q_neg: sign_a ^ sign_b, r_neg: sign_a};
          dvd     <= abs_a;
          divisor <= abs_b;
          rem     <= '0;
          quo     <= '0;
          cnt     <= '0;
          ready_o <= 1'b0;
          if (opB_i == '0) begin
            state         <= DONE;
            v_o           <= 1'b1;
            quotient_o    <= '1;
            remainder_o   <= opA_i;
            div_by_zero_o <= 1'b1;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          dvd <= {dvd[width_p-2:0], 1'b0};
          rem <= rem_nxt;
          quo <= q_fin;
          cnt <= cnt + ctr_w_lp'(1);
          if (cnt == last_lp) begin
            state         <= DONE;
            v_o           <= 1'b1;
            quotient_o    <= q_out;
            remainder_o   <= r_out;
            div_by_zero_o <= 1'b0;
          end
        end
        DONE: if (yumi_i) begin
          state   <= IDLE;
          v_o     <= 1'b0;
          ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_fma_int_div.sv
// Randomised and directed bench for bsg_fma_int_div against an arithmetic reference model.
module tb_bsg_fma_int_div;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         v_i = 1'b0;
  logic         signed_i = 1'b0;
  logic         yumi_i = 1'b0;
  logic [W-1:0] opA_i = '0;
  logic [W-1:0] opB_i = '0;
  logic         ready_o, v_o, div_by_zero_o;
  logic [W-1:0] quotient_o, remainder_o;

  bsg_fma_int_div #(.width_p(W)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .v_i           (v_i),
    .ready_o       (ready_o),
    .opA_i         (opA_i),
    .opB_i         (opB_i),
    .signed_i      (signed_i),
    .v_o           (v_o),
    .yumi_i        (yumi_i),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passed = 0;

  logic         exp_valid = 1'b0;
  logic [W-1:0] exp_q, exp_r;
  logic         exp_dbz;
  logic [W-1:0] got_q, got_r;
  logic         got_dbz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  // Plain arithmetic: 64-bit signed divide truncates toward zero and % follows the dividend.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
    longint sa, sb;
    if (b == '0) begin
      q = '1; r = a; dbz = 1'b1;
    end else begin
      dbz = 1'b0;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = W'(sa / sb);
        r  = W'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // Whenever a result is presented it must match the operation in flight.
  always @(negedge clk_i) begin
    if (reset_n_i && v_o) begin
      if (!exp_valid) check("spurious_v_o", 64'(v_o), 64'd0);
      else begin
        check("mon_q", 64'(quotient_o), 64'(exp_q));
        check("mon_r", 64'(remainder_o), 64'(exp_r));
        check("mon_dbz", 64'(div_by_zero_o), 64'(exp_dbz));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
    int n;
    n = 0;
    while (!ready_o && n < 100) begin @(posedge clk_i); #1; n++; end
    check("ready_before_op", 64'(ready_o), 64'd1);
    model(a, b, s, exp_q, exp_r, exp_dbz);
    opA_i = a; opB_i = b; signed_i = s; v_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0; opA_i = $urandom; opB_i = $urandom; signed_i = 1'($urandom);
    exp_valid = 1'b1;
    check("ready_low_after_accept", 64'(ready_o), 64'd0);
    // edges after the accept edge until v_o is seen
    n = 0;
    while (!v_o && n < W + 5) begin @(posedge clk_i); #1; n++; end
    if (b == '0) check("latency_dbz", 64'(n), 64'd0);
    else         check("latency", 64'(n), 64'(W));
    got_q = quotient_o; got_r = remainder_o; got_dbz = div_by_zero_o;
    for (int i = 0; i < hold; i++) begin
      v_i = 1'b1; opA_i = $urandom; opB_i = '0; signed_i = 1'($urandom);
      @(posedge clk_i); #1;
      check("hold_v_o", 64'(v_o), 64'd1);
      check("hold_ready", 64'(ready_o), 64'd0);
      check("hold_q", 64'(quotient_o), 64'(got_q));
      check("hold_r", 64'(remainder_o), 64'(got_r));
    end
    v_i = 1'b0;
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    exp_valid = 1'b0;
    check("ready_after_yumi", 64'(ready_o), 64'd1);
    check("v_o_after_yumi", 64'(v_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] mq, mr, a, b;
    logic         md, s;
    int           sel;

    // Model pinned by hand-computed values.
    model(32'd100, 32'd7, 1'b0, mq, mr, md);
    check("model_100_7_q", 64'(mq), 64'd14);
    check("model_100_7_r", 64'(mr), 64'd2);
    model(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr, md);
    check("model_m7_2_q", 64'(mq), 64'h0000_0000_FFFF_FFFD);
    check("model_m7_2_r", 64'(mr), 64'h0000_0000_FFFF_FFFF);
    model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr, md);
    check("model_ovf_q", 64'(mq), 64'h0000_0000_8000_0000);

    v_i = 1'b1; opA_i = 32'd55; opB_i = 32'd5;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_v_o", 64'(v_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_q", 64'(quotient_o), 64'd0);
    check("rst_r", 64'(remainder_o), 64'd0);
    check("rst_dbz", 64'(div_by_zero_o), 64'd0);
    v_i = 1'b0;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("v_i_ignored_in_reset", 64'(ready_o), 64'd1);

    // yumi with no result pending must be ignored
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    check("stray_yumi_ready", 64'(ready_o), 64'd1);
    check("stray_yumi_v_o", 64'(v_o), 64'd0);

    run_op(32'd100, 32'd7, 1'b0, 0);
    check("t1_q", 64'(got_q), 64'd14);
    check("t1_r", 64'(got_r), 64'd2);
    check("t1_dbz", 64'(got_dbz), 64'd0);

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    check("t2a_q", 64'(got_q), 64'h0000_0000_FFFF_FFFD);
    check("t2a_r", 64'(got_r), 64'h0000_0000_FFFF_FFFF);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    check("t2b_q", 64'(got_q), 64'h0000_0000_FFFF_FFFD);
    check("t2b_r", 64'(got_r), 64'd1);

    for (int m = 0; m < 2; m++) begin
      run_op(32'h1234, 32'd0, 1'(m), 0);
      check("t3_q", 64'(got_q), 64'h0000_0000_FFFF_FFFF);
      check("t3_r", 64'(got_r), 64'h1234);
      check("t3_dbz", 64'(got_dbz), 64'd1);
    end

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    check("t4a_q", 64'(got_q), 64'h0000_0000_8000_0000);
    check("t4a_r", 64'(got_r), 64'd0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    check("t4b_q", 64'(got_q), 64'h0000_0000_FFFF_FFFF);
    check("t4b_r", 64'(got_r), 64'd0);

    run_op(32'd1000, 32'd33, 1'b0, 10);
    check("t5_q", 64'(got_q), 64'd30);
    check("t5_r", 64'(got_r), 64'd10);

    // Reset in the middle of a calculation drops it.
    opA_i = 32'hDEAD_BEEF; opB_i = 32'd3; signed_i = 1'b0; v_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    check("yumi_in_calc_ready", 64'(ready_o), 64'd0);
    repeat (9) @(posedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("midcalc_rst_v_o", 64'(v_o), 64'd0);
    check("midcalc_rst_ready", 64'(ready_o), 64'd1);
    v_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    v_i = 1'b0;
    reset_n_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    check("no_result_after_rst", 64'(v_o), 64'd0);
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 0);
    check("t6_q", 64'(got_q), 64'h0FFF_FFFF);
    check("t6_r", 64'(got_r), 64'hF);

    for (int k = 0; k < 60; k++) begin
      a   = $urandom;
      sel = $urandom_range(0, 6);
      case (sel)
        0:       b = '0;
        1:       b = W'($urandom_range(1, 16));
        2:       b = '1;
        3:       begin b = '1; a = 32'h8000_0000; end
        default: b = $urandom >> $urandom_range(0, 24);
      endcase
      s = 1'($urandom);
      run_op(a, b, s, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
